exh_vector_sweeper: RTL and testbench

Parametrised on-chip successor to the fixed 5-bit exhaustive stimulus bench. It sweeps all 2^IN_W input vectors into a combinational DUT in binary or Gray order and waits a programmable settle time per vector. It captures the OUT_W-bit response and streams (vector, response) records over a valid/ready port. It also folds every response into a 16-bit MISR signature for golden-vs-suspect trojan comparison.

---
 rtl/exh_vector_sweeper.sv | 119 +++++++++++
 tb/tb_exh_vector_sweeper.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exh_vector_sweeper.sv
// rtl/exh_vector_sweeper.sv - exhaustive binary/Gray vector sweeper with record stream and MISR
module exh_vector_sweeper #(
  parameter int IN_W   = 5,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              gray_mode,
  input  logic              abort,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [IN_W-1:0]   rec_vec,
  output logic [OUT_W-1:0]  rec_resp,
  output logic [IN_W:0]     vec_count,
  output logic [15:0]       signature,
  output logic              busy,
  output logic              done
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [IN_W:0] IDX_LAST = {1'b0, {IN_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, APPLY, OUT} state_t;

  state_t          state;
  logic            mode;
  logic [CW-1:0]   cnt;
  logic [IN_W-1:0] next_lo;
  logic [15:0]     resp16;
  logic [15:0]     misr_next;

  function automatic logic [IN_W-1:0] vec_of(input logic [IN_W-1:0] b, input logic g);
    return g ? (b ^ (b >> 1)) : b;
  endfunction

  assign next_lo = vec_count[IN_W-1:0] + IN_W'(1);

  always_comb begin
    resp16 = '0;
    resp16[OUT_W-1:0] = dut_out;
  end

  assign misr_next = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000) ^ resp16;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mode      <= 1'b0;
      cnt       <= '0;
      dut_in    <= '0;
      rec_valid <= 1'b0;
      rec_vec   <= '0;
      rec_resp  <= '0;
      vec_count <= '0;
      signature <= 16'hFFFF;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= APPLY;
            mode      <= gray_mode;
            cnt       <= '0;
            vec_count <= '0;
            dut_in    <= '0;
            signature <= 16'hFFFF;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        APPLY: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rec_valid <= 1'b0;
            done      <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            // capture only after dut_in has been held for the full settle window
            rec_resp  <= dut_out;
            rec_vec   <= dut_in;
            signature <= misr_next;
            rec_valid <= 1'b1;
            state     <= OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        OUT: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rec_valid <= 1'b0;
            done      <= 1'b0;
          end else if (rec_ready) begin
            rec_valid <= 1'b0;
            if (vec_count == IDX_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              vec_count <= vec_count + (IN_W+1)'(1);
              dut_in    <= vec_of(next_lo, mode);
              cnt       <= '0;
              state     <= APPLY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exh_vector_sweeper.sv
// tb/tb_exh_vector_sweeper.sv - scoreboard bench for exh_vector_sweeper
module tb_exh_vector_sweeper;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic        reset, start, gray_mode, abort, rec_ready;
  logic [4:0]  dut_in, rec_vec;
  logic        dut_out, rec_resp, rec_valid, busy, done;
  logic [5:0]  vec_count;
  logic [15:0] signature;

  logic        start_b, gray_mode_b, abort_b, rec_ready_b;
  logic [4:0]  dut_in_b, rec_vec_b;
  logic        dut_out_b, rec_resp_b, rec_valid_b, busy_b, done_b;
  logic [5:0]  vec_count_b;
  logic [15:0] signature_b;
  logic        inv_d1, inv_d2;

  assign dut_out = &dut_in;

  // two-stage registered inverter: the response lags dut_in_b by two cycles
  always @(posedge CK or negedge reset) begin
    if (!reset) begin
      inv_d1 <= 1'b0;
      inv_d2 <= 1'b0;
    end else begin
      inv_d1 <= ~dut_in_b[0];
      inv_d2 <= inv_d1;
    end
  end
  assign dut_out_b = inv_d2;

  exh_vector_sweeper #(.IN_W(5), .OUT_W(1), .SETTLE(1)) dut_a (
    .CK(CK), .reset(reset), .start(start), .gray_mode(gray_mode), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vec(rec_vec), .rec_resp(rec_resp), .vec_count(vec_count),
    .signature(signature), .busy(busy), .done(done)
  );

  exh_vector_sweeper #(.IN_W(5), .OUT_W(1), .SETTLE(4)) dut_b (
    .CK(CK), .reset(reset), .start(start_b), .gray_mode(gray_mode_b), .abort(abort_b),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
    .rec_vec(rec_vec_b), .rec_resp(rec_resp_b), .vec_count(vec_count_b),
    .signature(signature_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic [4:0] vec;
    logic       resp;
    logic [5:0] idx;
  } rec_t;

  rec_t        q_a[$];
  rec_t        q_b[$];
  rec_t        ea, eb;
  int          checks = 0;
  int          failures = 0;
  time         last_hs = 0;
  logic [15:0] exp_sig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r};
  endfunction

  task automatic push_sweep(input bit g, input int n);
    logic [4:0] v;
    rec_t e;
    exp_sig = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      v = 5'(i);
      if (g) v = v ^ (v >> 1);
      e.vec = v;
      e.resp = &v;
      e.idx = 6'(i);
      q_a.push_back(e);
      exp_sig = misr(exp_sig, e.resp);
    end
  endtask

  always @(negedge CK) begin
    if (reset === 1'b1 && rec_valid === 1'b1 && rec_ready === 1'b1 && abort === 1'b0) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record actual_vec=%0h expected=none", rec_vec);
      end else begin
        ea = q_a.pop_front();
        chk("rec_vec", rec_vec, ea.vec);
        chk("rec_resp", rec_resp, ea.resp);
        chk("vec_count", vec_count, ea.idx);
        if (q_a.size() == 0) last_hs = $time;
      end
    end
  end

  always @(negedge CK) begin
    if (reset === 1'b1 && rec_valid_b === 1'b1 && rec_ready_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_record_b actual_vec=%0h expected=none", rec_vec_b);
      end else begin
        eb = q_b.pop_front();
        chk("b_rec_vec", rec_vec_b, eb.vec);
        chk("b_rec_resp", rec_resp_b, eb.resp);
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic do_start(input bit g);
    tick();
    start = 1'b1;
    gray_mode = g;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_cyc, output time t_done);
    bit seen = 0;
    busy_cyc = 0;
    t_done = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge CK);
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1;
        t_done = $time;
      end
    end
    chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_rec_valid"}, rec_valid, 0);
    chk({tag, "_rec_vec"}, rec_vec, 0);
    chk({tag, "_rec_resp"}, rec_resp, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_signature"}, signature, 32'hFFFF);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int bc;
    time td;
    bit stalled, found;
    logic [4:0] sv, sd;
    logic sr;

    reset = 1'b0; start = 1'b0; gray_mode = 1'b0; abort = 1'b0; rec_ready = 1'b1;
    start_b = 1'b0; gray_mode_b = 1'b0; abort_b = 1'b0; rec_ready_b = 1'b1;
    #12;
    check_reset_outputs("por");
    tick();
    reset = 1'b1;

    // binary sweep, ready tied high
    push_sweep(0, 32);
    do_start(0);
    wait_done("bin", bc, td);
    chk("bin_busy_cycles", bc, 64);
    chk("bin_done_latency", 32'(td - last_hs), 10);
    chk("bin_signature", signature, exp_sig);
    chk("bin_dut_in_hold", dut_in, 5'h1F);
    chk("bin_vec_count", vec_count, 31);
    chk("bin_rec_valid", rec_valid, 0);
    chk("bin_q_empty", q_a.size(), 0);

    // Gray sweep, with a start issued mid-sweep that must be ignored
    push_sweep(1, 32);
    do_start(1);
    repeat (5) tick();
    start = 1'b1;
    gray_mode = 1'b0;
    tick();
    start = 1'b0;
    wait_done("gray", bc, td);
    chk("gray_signature", signature, exp_sig);
    chk("gray_dut_in_last", dut_in, 5'h10);
    chk("gray_q_empty", q_a.size(), 0);

    // toggling ready with a 3-cycle stall on record 7
    push_sweep(0, 32);
    do_start(0);
    stalled = 0;
    for (int k = 0; k < 2000 && !done; k++) begin
      tick();
      if (rec_valid && rec_vec == 5'd7 && !stalled) begin
        rec_ready = 1'b0;
        sv = rec_vec; sr = rec_resp; sd = dut_in;
        repeat (3) begin
          @(negedge CK);
          chk("stall_rec_valid", rec_valid, 1);
          chk("stall_rec_vec", rec_vec, sv);
          chk("stall_rec_resp", rec_resp, sr);
          chk("stall_dut_in", dut_in, sd);
        end
        tick();
        rec_ready = 1'b1;
        stalled = 1;
      end else begin
        rec_ready = ~rec_ready;
      end
    end
    rec_ready = 1'b1;
    chk("stall_seen", {31'b0, stalled}, 1);
    chk("stall_done", done, 1);
    chk("stall_signature", signature, exp_sig);
    chk("stall_q_empty", q_a.size(), 0);

    // SETTLE=4 instance against a two-cycle-latency inverter
    for (int i = 0; i < 32; i++) begin
      eb.vec = 5'(i);
      eb.resp = ~eb.vec[0];
      eb.idx = 6'(i);
      q_b.push_back(eb);
    end
    tick();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    found = 0;
    for (int k = 0; k < 1000 && !found; k++) begin
      @(negedge CK);
      if (done_b) found = 1;
    end
    chk("b_done_seen", {31'b0, found}, 1);
    chk("b_q_empty", q_b.size(), 0);
    chk("b_busy", busy_b, 0);

    // abort in OUT of record 10 while ready is high
    rec_ready = 1'b1;
    push_sweep(0, 10);
    exp_sig = misr(exp_sig, 1'b0);
    do_start(0);
    found = 0;
    for (int k = 0; k < 500 && !found; k++) begin
      tick();
      if (rec_valid && rec_vec == 5'd10) found = 1;
    end
    chk("abort_target_seen", {31'b0, found}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rec_valid", rec_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_vec_count", vec_count, 10);
    chk("abort_signature", signature, exp_sig);
    chk("abort_q_empty", q_a.size(), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_vec_count", vec_count, 10);
    push_sweep(0, 32);
    do_start(0);
    chk("restart_signature", signature, 32'hFFFF);
    chk("restart_vec_count", vec_count, 0);
    chk("restart_dut_in", dut_in, 0);
    chk("restart_busy", busy, 1);
    wait_done("restart", bc, td);
    chk("restart_final_signature", signature, exp_sig);
    chk("restart_q_empty", q_a.size(), 0);

    // asynchronous reset during APPLY of record 5
    push_sweep(0, 5);
    do_start(0);
    found = 0;
    for (int k = 0; k < 500 && !found; k++) begin
      tick();
      if (vec_count == 6'd5 && busy && !rec_valid) found = 1;
    end
    chk("reset_target_seen", {31'b0, found}, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_reset_rec_valid", rec_valid, 0);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_q_empty", q_a.size(), 0);
    push_sweep(0, 32);
    do_start(0);
    wait_done("post_reset", bc, td);
    chk("post_reset_busy_cycles", bc, 64);
    chk("post_reset_signature", signature, exp_sig);
    chk("post_reset_sweep_q_empty", q_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
